// File: rtl/rsp_frame_pkg.sv
// rsp_frame_pkg: shared response/command frame definitions.
//   HEADER / LENGTH / TAIL : fixed frame bytes (also used by the command receiver)
//   frame_state_e          : one-hot transmitter state encoding
//   frame_phase_e          : SEND / WAIT sub-phase of every byte state
//   next_byte_state()      : byte sequencing of a frame
// Optional feature: RSP_CHECKSUM_EN adds a CHKSUM byte state between DATAC and TAIL.
package rsp_frame_pkg;

  localparam logic [7:0] HEADER = 8'hAA;
  localparam logic [7:0] LENGTH = 8'd3;
  localparam logic [7:0] TAIL   = 8'h88;

`ifdef RSP_CHECKSUM_EN
  localparam int unsigned STATE_W = 8;
`else
  localparam int unsigned STATE_W = 7;
`endif

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = STATE_W'(1),
    ST_HEADER = STATE_W'(2),
    ST_LENGTH = STATE_W'(4),
    ST_DATAA  = STATE_W'(8),
    ST_DATAB  = STATE_W'(16),
    ST_DATAC  = STATE_W'(32),
    ST_TAIL   = STATE_W'(64)
`ifdef RSP_CHECKSUM_EN
    , ST_CHKSUM = STATE_W'(128)
`endif
  } frame_state_e;

  typedef enum logic {
    PH_SEND = 1'b0,
    PH_WAIT = 1'b1
  } frame_phase_e;

  // Byte state that follows s once its byte is done; TAIL (and anything
  // unexpected) falls back to IDLE.
  function automatic frame_state_e next_byte_state(input frame_state_e s);
    frame_state_e n;
    n = ST_IDLE;
    case (s)
      ST_HEADER: n = ST_LENGTH;
      ST_LENGTH: n = ST_DATAA;
      ST_DATAA:  n = ST_DATAB;
      ST_DATAB:  n = ST_DATAC;
`ifdef RSP_CHECKSUM_EN
      ST_DATAC:  n = ST_CHKSUM;
      ST_CHKSUM: n = ST_TAIL;
`else
      ST_DATAC:  n = ST_TAIL;
`endif
      default:   n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rsp_frame_tx.sv
// rsp_frame_tx: serialises one register-read response frame onto a byte UART.
// Frame: HEADER, LENGTH, s_addr, s_data[15:8], s_data[7:0], [CHKSUM], TAIL.
// Ports:
//   Clk, Rst_n      clock, asynchronous active-low reset
//   s_req           one-cycle request; accepted when s_ready is high
//   s_addr, s_data  payload captured on acceptance
//   s_ready         high only while idle
//   s_drop          one-cycle pulse (cycle after) for a request made while busy
//   Tx_Byte         byte presented to the UART, stable through its WAIT phase
//   Tx_Send         one-cycle start pulse to the UART
//   Tx_Done         UART byte-finished pulse; only honoured in a WAIT phase
// Macro RSP_CHECKSUM_EN: insert XOR(DATAA,DATAB,DATAC) byte before TAIL.
module rsp_frame_tx
  import rsp_frame_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        s_req,
  input  logic [7:0]  s_addr,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic        s_drop,
  output logic [7:0]  Tx_Byte,
  output logic        Tx_Send,
  input  logic        Tx_Done
);

  frame_state_e state_q, state_d;
  frame_phase_e phase_q, phase_d;
  logic [7:0]   addr_q, addr_d;
  logic [15:0]  data_q, data_d;
  logic         drop_q, drop_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= PH_SEND;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    data_d  = data_q;
    drop_d  = s_req && (state_q != ST_IDLE);
    if (state_q == ST_IDLE) begin
      phase_d = PH_SEND;
      if (s_req) begin
        addr_d  = s_addr;
        data_d  = s_data;
        state_d = ST_HEADER;
      end
    end else if (phase_q == PH_SEND) begin
      // SEND lasts exactly one cycle regardless of Tx_Done.
      phase_d = PH_WAIT;
    end else if (Tx_Done) begin
      state_d = next_byte_state(state_q);
      phase_d = PH_SEND;
    end
  end

  always_comb begin
    s_ready = (state_q == ST_IDLE);
    s_drop  = drop_q;
    Tx_Send = (state_q != ST_IDLE) && (phase_q == PH_SEND);
    Tx_Byte = '0;
    case (state_q)
      ST_HEADER: Tx_Byte = HEADER;
      ST_LENGTH: Tx_Byte = LENGTH;
      ST_DATAA:  Tx_Byte = addr_q;
      ST_DATAB:  Tx_Byte = data_q[15:8];
      ST_DATAC:  Tx_Byte = data_q[7:0];
`ifdef RSP_CHECKSUM_EN
      ST_CHKSUM: Tx_Byte = addr_q ^ data_q[15:8] ^ data_q[7:0];
`endif
      ST_TAIL:   Tx_Byte = TAIL;
      default:   Tx_Byte = '0;
    endcase
  end

endmodule

// File: doc/rsp_frame_tx.md
RSP_FRAME_TX -- requirements
Module: rsp_frame_tx

Interface
REQ-001 Clk  input  1  system clock; all logic on its rising edge.
REQ-002 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 s_req  input  1  single-cycle request to send one response frame.
REQ-004 s_addr  input  8  register address, carried in frame byte DATAA.
REQ-005 s_data  input  16  register data; [15:8] goes in DATAB, [7:0] in DATAC.
REQ-006 s_ready  output  1  high when a request will be accepted this cycle.
REQ-007 s_drop  output  1  one-cycle pulse when s_req arrives while s_ready is low.
REQ-008 Tx_Byte  output  8  byte presented to the UART transmitter.
REQ-009 Tx_Send  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 Tx_Done  input  1  one-cycle pulse from the UART transmitter when the byte has finished.
REQ-011 Constants (package): HEADER 8'hAA frame head; LENGTH 8'd3 payload byte count; TAIL 8'h88 frame tail.

Function
REQ-012 Frame order SHALL be HEADER, LENGTH, DATAA=s_addr, DATAB=s_data[15:8], DATAC=s_data[7:0], TAIL.
REQ-013 Request acceptance: s_req=1 with s_ready=1 SHALL capture s_addr/s_data into internal registers that same edge.
REQ-014 s_ready SHALL be 1 only in IDLE; it SHALL drop the cycle after acceptance and return the cycle after TAIL's Tx_Done.
REQ-015 A request while s_ready=0 SHALL be ignored (captured data unchanged, frame unaffected) and SHALL pulse s_drop for 1 cycle.
REQ-016 States, one-hot: IDLE, HEADER, LENGTH, DATAA, DATAB, DATAC, TAIL; each byte state has a SEND phase and a WAIT phase.
REQ-017 SEND phase: Tx_Byte set to the state's byte and Tx_Send=1 for exactly one cycle; then WAIT.
REQ-018 WAIT phase: hold Tx_Byte stable; on Tx_Done move to the next byte state's SEND phase in the following cycle.
REQ-019 Latency: the HEADER Tx_Send SHALL be asserted the cycle after acceptance; with an ideal Tx_Done in the cycle after Tx_Send, a frame takes 12 cycles from acceptance to TAIL done.
REQ-020 Tx_Done while in IDLE or a SEND phase SHALL be ignored.
REQ-021 Tx_Send SHALL never be asserted in two consecutive cycles, and never outside a SEND phase.
REQ-022 After TAIL's Tx_Done the FSM SHALL return to IDLE; a request in that same cycle is not accepted (s_ready still 0).

Reset
REQ-023 While Rst_n=0: state=IDLE, Tx_Send=0, Tx_Byte=8'h00, s_drop=0, captured addr/data=0; s_ready=1 after release.
REQ-024 Reset mid-frame SHALL abort the frame immediately; no partial bytes are resumed after release.

Configuration
REQ-025 Macro RSP_CHECKSUM_EN defined: a CHKSUM state is inserted between DATAC and TAIL, sending the XOR of DATAA, DATAB and DATAC; LENGTH is still 8'd3; a frame is 7 bytes and takes 14 cycles under REQ-019 conditions.
REQ-026 Macro RSP_CHECKSUM_EN undefined: no CHKSUM state or logic; the frame is exactly per REQ-012.

Structure
REQ-027 HEADER, LENGTH and TAIL SHALL live in a shared frame package, which the command receiver also uses.
REQ-028 The state encoding SHALL live in the same shared frame package.
REQ-029 No sub-module is required; the block is a single FSM with a capture register.

Verification
REQ-030 Request s_addr=8'h12, s_data=16'h3456 with immediate Tx_Done -> bytes AA,03,12,34,56,88; 6 Tx_Send pulses; s_ready returns after 12 cycles.
REQ-031 Same request with RSP_CHECKSUM_EN defined -> bytes AA,03,12,34,56,70,88.
REQ-032 Second s_req during frame (addr 8'h99) -> s_drop pulses once; the in-flight frame still carries 8'h12; no second frame is sent.
REQ-033 Tx_Done delayed 100 cycles per byte -> Tx_Byte held stable and no extra Tx_Send; spurious Tx_Done in IDLE -> no output activity.
REQ-034 Rst_n low after the DATAA byte is done -> Tx_Send=0, s_ready=1 after release; the next request sends a complete fresh frame starting with AA.
REQ-035 Back-to-back requests, each issued the first cycle s_ready=1 -> two complete frames; no s_drop pulses.
